// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the signed ALU and its command driver:
//   - ALU opcode values (ADD = 0 through LT = 13; 14 and 15 are undefined and
//     are reported by the ALU through its E flag)
//   - bit positions of each flag inside the 5-bit {Z,C,V,S,E} flag vector
//   - state encoding of the command driver FSM
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_SHR = 4'd10;
    localparam logic [3:0] OP_SAR = 4'd11;
    localparam logic [3:0] OP_EQ  = 4'd12;
    localparam logic [3:0] OP_LT  = 4'd13;

    // Bit positions inside the {Z,C,V,S,E} flag vector.
    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_E = 0;

    // IDLE is the all-zero code so the state debug output reads 0 in reset.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_FLAGS = 3'd3,
        S_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/alu_cmd_driver_if.sv
// ----------------------------------------------------------------------------
// alu_cmd_driver_if
//   Bus between the command driver (master) and the signed ALU (slave).
//   Parameter N: operand width; the result is 2N bits wide.
//   master: drives alu_start/alu_opcode/alu_a/alu_b, receives ready/result/flags
//   slave : the ALU side, mirror image of master
// ----------------------------------------------------------------------------
interface alu_cmd_driver_if #(
    parameter int N = 8
);
    logic           alu_start;
    logic [3:0]     alu_opcode;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic           alu_ready;
    logic [2*N-1:0] alu_result;
    logic           alu_z;
    logic           alu_c;
    logic           alu_v;
    logic           alu_s;
    logic           alu_e;

    modport master (
        output alu_start, alu_opcode, alu_a, alu_b,
        input  alu_ready, alu_result, alu_z, alu_c, alu_v, alu_s, alu_e
    );

    modport slave (
        input  alu_start, alu_opcode, alu_a, alu_b,
        output alu_ready, alu_result, alu_z, alu_c, alu_v, alu_s, alu_e
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// ----------------------------------------------------------------------------
// alu_cmd_fifo
//   Synchronous FIFO holding packed host commands {opcode, a, b}.
//   Parameters: DEPTH (power of two, >= 2), WIDTH (entry width).
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset (pointers only)
//     push, wdata     write request; ignored when full, even if popping
//     pop, rdata      read request; rdata always shows the head entry
//     full, empty     occupancy status
//   Pointers carry one extra wrap bit so full and empty are distinguishable
//   when the index bits match.
// ----------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// ----------------------------------------------------------------------------
// alu_cmd_driver
//   Initiator-side sequencer for the signed ALU. Host commands are queued in
//   a FIFO; each one is issued to the ALU with a one-cycle start pulse, the
//   result and flags are gathered (Z/S arrive one cycle after ready) and one
//   response per command is offered on the rsp_* port.
//
//   Optional feature: define ALU_DRV_TIMEOUT_EN to abandon an ALU operation
//   after TIMEOUT cycles in WAIT; the response then carries result 0, flags
//   E only, and rsp_timeout = 1. Without it WAIT waits indefinitely and
//   rsp_timeout is constant 0.
//
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     cmd_valid/cmd_ready        command handshake, cmd_opcode/cmd_a/cmd_b
//     alu                        master side of the ALU bus
//     rsp_valid/rsp_ready        response handshake, rsp_opcode/rsp_result/
//                                rsp_flags ({Z,C,V,S,E})/rsp_timeout
//     busy                       FSM not IDLE or FIFO non-empty
//     err_count                  saturating count of responses with E = 1
//     dbg_state                  current FSM state
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both 1. rsp_valid, once raised, stays high with every rsp_* field
//   unchanged until that transfer; cmd_ready depends only on FIFO state.
// ----------------------------------------------------------------------------
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int N       = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_opcode,
    input  logic [N-1:0]       cmd_a,
    input  logic [N-1:0]       cmd_b,
    alu_cmd_driver_if.master   alu,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [3:0]         rsp_opcode,
    output logic [2*N-1:0]     rsp_result,
    output logic [4:0]         rsp_flags,
    output logic               rsp_timeout,
    output logic               busy,
    output logic [7:0]         err_count,
    output state_t             dbg_state
);
    localparam int CW = 4 + 2*N;

    state_t         state_q, state_d;
    logic           init_q;
    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_wdata, fifo_rdata;
    logic [3:0]     op_q;
    logic [N-1:0]   a_q, b_q;
    logic [2*N-1:0] result_q;
    logic [4:0]     flags_q;
    logic           timeout_q;
    logic [7:0]     err_q;
    logic           tmo_hit;

    // init_q keeps cmd_ready low until the first edge after reset release.
    assign cmd_ready  = init_q && !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_wdata = {cmd_opcode, cmd_a, cmd_b};

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef ALU_DRV_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt_q;

    // Counts WAIT cycles; the count equals TIMEOUT in the (TIMEOUT+1)-th
    // WAIT cycle, so rsp_valid rises TIMEOUT+2 cycles after alu_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                wait_cnt_q <= '0;
        else if (state_q != S_WAIT) wait_cnt_q <= '0;
        else                       wait_cnt_q <= wait_cnt_q + TW'(1);
    end

    // A ready arriving in the final WAIT cycle still wins over the timeout.
    assign tmo_hit = (state_q == S_WAIT) && !alu.alu_ready &&
                     (wait_cnt_q == TW'(TIMEOUT));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (alu.alu_ready) state_d = S_FLAGS;
                else if (tmo_hit)  state_d = S_RESP;
            end
            S_FLAGS: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand, result and flag registers. Everything visible on rsp_* is
    // loaded before RESP and left untouched while in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            timeout_q <= 1'b0;
            err_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        {op_q, a_q, b_q} <= fifo_rdata;
                        timeout_q        <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (alu.alu_ready) begin
                        result_q         <= alu.alu_result;
                        flags_q          <= '0;
                        flags_q[FLAG_C]  <= alu.alu_c;
                        flags_q[FLAG_V]  <= alu.alu_v;
                        flags_q[FLAG_E]  <= alu.alu_e;
                    end else if (tmo_hit) begin
                        result_q         <= '0;
                        flags_q          <= '0;
                        flags_q[FLAG_E]  <= 1'b1;
                        timeout_q        <= 1'b1;
                    end
                end
                // Z and S lag the ready pulse by one cycle.
                S_FLAGS: begin
                    flags_q[FLAG_Z] <= alu.alu_z;
                    flags_q[FLAG_S] <= alu.alu_s;
                end
                S_RESP: begin
                    if (rsp_ready && flags_q[FLAG_E] && (err_q != 8'hFF))
                        err_q <= err_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign alu.alu_start  = (state_q == S_ISSUE);
    assign alu.alu_opcode = op_q;
    assign alu.alu_a      = a_q;
    assign alu.alu_b      = b_q;

    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_opcode = op_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
`ifdef ALU_DRV_TIMEOUT_EN
    assign rsp_timeout = timeout_q;
`else
    logic unused_timeout_q;
    assign unused_timeout_q = timeout_q;
    assign rsp_timeout      = 1'b0;
`endif
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign err_count  = err_q;
    assign dbg_state  = state_q;

endmodule
